// File: rtl/eprom_fetch_if.sv
// eprom_fetch_if: CPU-side word-read handshake for the EPROM fetch controller
interface eprom_fetch_if #(
  parameter int ADDR_W     = 20,
  parameter int WORD_BYTES = 2
);
  logic                    req;
  logic [ADDR_W-1:0]       addr;
  logic                    busy;
  logic                    ack;
  logic [8*WORD_BYTES-1:0] rdata;
  modport master (output req, addr, input busy, ack, rdata);
  modport slave  (input req, addr, output busy, ack, rdata);
endinterface

// File: rtl/eprom_fetch_ctrl.sv
// eprom_fetch_ctrl: EPROM bus master assembling big-endian words from sequential byte reads
// Define EPROM_PREFETCH_EN to add a one-word background prefetch buffer.
module eprom_fetch_ctrl #(
  parameter int WORD_BYTES  = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  eprom_fetch_if.slave      bus,
  output logic              _rom_cs,
  output logic              _rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data
);
  localparam int DW = 8 * WORD_BYTES;
  localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, DONE} state_t;
  state_t          state;
  logic [1:0]      idx;
  logic [WW-1:0]   wcnt;
  logic            busy;
  logic            ack;
  logic [DW-1:0]   rdata;
  logic            last;
  assign last      = idx == 2'(WORD_BYTES - 1);
  assign bus.busy  = busy;
  assign bus.ack   = ack;
  assign bus.rdata = rdata;
`ifdef EPROM_PREFETCH_EN
  logic              bg;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              pf_valid;
  logic [ADDR_W-1:0] pf_addr;
  logic [DW-1:0]     pf_data;
  logic [ADDR_W-1:0] base;
  logic              req_eff;
  logic [ADDR_W-1:0] addr_eff;
  // a request that arrived during a background fetch is replayed from pend
  assign req_eff  = bus.req || pend;
  assign addr_eff = pend ? pend_addr : bus.addr;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wcnt     <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      rdata    <= '0;
      _rom_cs  <= 1'b1;
      _rom_oe  <= 1'b1;
      rom_addr <= '0;
`ifdef EPROM_PREFETCH_EN
      bg        <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pf_valid  <= 1'b0;
      pf_addr   <= '0;
      pf_data   <= '0;
      base      <= '0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef EPROM_PREFETCH_EN
      if (bg && !pend && state != IDLE && bus.req) begin
        pend      <= 1'b1;
        pend_addr <= bus.addr;
        busy      <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
`ifdef EPROM_PREFETCH_EN
          if (req_eff) begin
            pend <= 1'b0;
            busy <= 1'b1;
            if (pf_valid && addr_eff == pf_addr) begin
              state <= DONE;
              ack   <= 1'b1;
              rdata <= pf_data;
              base  <= pf_addr;
            end else begin
              state    <= SETUP;
              rom_addr <= addr_eff;
              base     <= addr_eff;
              idx      <= '0;
              pf_valid <= 1'b0;
              _rom_cs  <= 1'b0;
              _rom_oe  <= 1'b1;
            end
          end
`else
          if (bus.req) begin
            state    <= SETUP;
            rom_addr <= bus.addr;
            idx      <= '0;
            busy     <= 1'b1;
            _rom_cs  <= 1'b0;
            _rom_oe  <= 1'b1;
          end
`endif
        end
        SETUP: begin
          state   <= ACCESS;
          wcnt    <= '0;
          _rom_oe <= 1'b0;
        end
        ACCESS: begin
          if (wcnt == WW'(WAIT_CYCLES - 1)) state <= CAPTURE;
          else wcnt <= wcnt + 1'b1;
        end
        CAPTURE: begin
`ifdef EPROM_PREFETCH_EN
          for (int i = 0; i < WORD_BYTES; i++)
            if (idx == 2'(WORD_BYTES - 1 - i)) begin
              if (bg) pf_data[8*i +: 8] <= rom_data;
              else rdata[8*i +: 8] <= rom_data;
            end
          if (bg && pend && pend_addr != pf_addr) begin
            state    <= SETUP;
            bg       <= 1'b0;
            pend     <= 1'b0;
            base     <= pend_addr;
            rom_addr <= pend_addr;
            idx      <= '0;
            _rom_oe  <= 1'b1;
          end else if (!last) begin
            state    <= SETUP;
            idx      <= idx + 1'b1;
            rom_addr <= rom_addr + 1'b1;
            _rom_oe  <= 1'b1;
          end else if (bg) begin
            state    <= IDLE;
            bg       <= 1'b0;
            pf_valid <= 1'b1;
            busy     <= 1'b0;
            _rom_cs  <= 1'b1;
            _rom_oe  <= 1'b1;
          end else begin
            state   <= DONE;
            ack     <= 1'b1;
            _rom_cs <= 1'b1;
            _rom_oe <= 1'b1;
          end
`else
          for (int i = 0; i < WORD_BYTES; i++)
            if (idx == 2'(WORD_BYTES - 1 - i)) rdata[8*i +: 8] <= rom_data;
          if (!last) begin
            state    <= SETUP;
            idx      <= idx + 1'b1;
            rom_addr <= rom_addr + 1'b1;
            _rom_oe  <= 1'b1;
          end else begin
            state   <= DONE;
            ack     <= 1'b1;
            _rom_cs <= 1'b1;
            _rom_oe <= 1'b1;
          end
`endif
        end
        DONE: begin
`ifdef EPROM_PREFETCH_EN
          // every delivered word launches a background fetch of its successor
          state    <= SETUP;
          bg       <= 1'b1;
          rom_addr <= base + ADDR_W'(WORD_BYTES);
          pf_addr  <= base + ADDR_W'(WORD_BYTES);
          pf_valid <= 1'b0;
          idx      <= '0;
          busy     <= 1'b0;
          _rom_cs  <= 1'b0;
          _rom_oe  <= 1'b1;
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eprom_fetch_ctrl.sv
// tb_eprom_fetch_ctrl: directed checks of the EPROM fetch controller against a behavioural ROM
module tb_eprom_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rom_cs;
  logic        rom_oe;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  int          checks = 0;
  int          errors = 0;
  eprom_fetch_if #(.ADDR_W(20), .WORD_BYTES(2)) bus ();
  eprom_fetch_ctrl #(.WORD_BYTES(2), .WAIT_CYCLES(2), .ADDR_W(20)) dut (
    .clk(clk), .reset(reset), .bus(bus), ._rom_cs(rom_cs), ._rom_oe(rom_oe),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rom_at(input logic [19:0] a);
    case (a)
      20'h00010: return 8'hA5;
      20'h00011: return 8'h3C;
      20'hFFFFF: return 8'h12;
      20'h00000: return 8'h34;
      default:   return a[7:0] ^ 8'h5A;
    endcase
  endfunction
  // ECL part: data reads 0 unless selected and enabled
  always_comb rom_data = (!rom_cs && !rom_oe) ? rom_at(rom_addr) : 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // lat counts edges from the first edge that sees req high up to the edge raising ack
  task automatic do_read(input string tag, input logic [19:0] a, input logic [15:0] exp_d,
                         input int exp_lat, input int settle, input bit pins,
                         input logic [19:0] exp_first, input logic [19:0] exp_last);
    int          lat = 0;
    int          oe_low = 0;
    bit          got_first = 0;
    logic [19:0] first_a = '0;
    logic [19:0] last_a = '0;
    repeat (settle) @(posedge clk);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = a;
    for (int k = 0; k < 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.req = 1'b0;
      if (!rom_oe) begin
        oe_low++;
        if (!got_first) first_a = rom_addr;
        got_first = 1;
        last_a = rom_addr;
      end
      if (bus.ack) lat = k + 1;
    end
    check({tag, " ack_seen"}, 32'(lat != 0), 32'd1);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, {16'h0, bus.rdata}, {16'h0, exp_d});
    check({tag, " busy_at_ack"}, {31'h0, bus.busy}, 32'd1);
    if (pins) begin
      check({tag, " oe_low_cycles"}, oe_low, 6);
      check({tag, " first_addr"}, {12'h0, first_a}, {12'h0, exp_first});
      check({tag, " last_addr"}, {12'h0, last_a}, {12'h0, exp_last});
      check({tag, " cs_at_ack"}, {31'h0, rom_cs}, 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, " ack_pulse"}, {31'h0, bus.ack}, 32'd0);
    check({tag, " busy_after"}, {31'h0, bus.busy}, 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int acks;
    int prev;
    reset    = 1'b1;
    bus.req  = 1'b0;
    bus.addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cs", {31'h0, rom_cs}, 32'd1);
    check("rst oe", {31'h0, rom_oe}, 32'd1);
    check("rst ack", {31'h0, bus.ack}, 32'd0);
    check("rst rdata", {16'h0, bus.rdata}, 32'h0);
    check("rst busy", {31'h0, bus.busy}, 32'd0);
    check("rst rom_addr", {12'h0, rom_addr}, 32'h0);
    reset = 1'b0;
    do_read("rd10", 20'h00010, 16'hA53C, 9, 2, 1, 20'h00010, 20'h00011);
    do_read("wrap", 20'hFFFFF, 16'h1234, 9, 20, 1, 20'hFFFFF, 20'h00000);
    // reset lands on the edge that ends the second ACCESS cycle
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = 20'h00010;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort cs", {31'h0, rom_cs}, 32'd1);
    check("abort oe", {31'h0, rom_oe}, 32'd1);
    check("abort busy", {31'h0, bus.busy}, 32'd0);
    check("abort ack", {31'h0, bus.ack}, 32'd0);
    reset = 1'b0;
    acks  = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack) acks++;
    end
    check("abort no_ack", acks, 0);
    do_read("post_abort", 20'h00010, 16'hA53C, 9, 0, 1, 20'h00010, 20'h00011);
`ifndef EPROM_PREFETCH_EN
    // req held high: DONE ignores req, so acks recur every 10 edges
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = 20'h00010;
    acks = 0;
    prev = -1;
    for (int c = 0; c < 42; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        acks++;
        check("held rdata", {16'h0, bus.rdata}, 32'h0000A53C);
        if (prev < 0) check("held first_ack", c, 8);
        else check("held spacing", c - prev, 10);
        prev = c;
      end
    end
    bus.req = 1'b0;
    check("held ack_count", acks, 4);
    repeat (20) @(posedge clk);
`else
    do_read("pf_miss10", 20'h00010, 16'hA53C, 9, 20, 1, 20'h00010, 20'h00011);
    do_read("pf_hit12", 20'h00012, 16'h4849, 1, 20, 0, 20'h0, 20'h0);
    do_read("pf_drop40", 20'h00040, 16'h1A1B, 0, 3, 0, 20'h0, 20'h0);
    do_read("pf_hit42", 20'h00042, 16'h1819, 1, 20, 0, 20'h0, 20'h0);
    repeat (20) @(posedge clk);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
